// File: rtl/shift_exec_unit_pkg.sv
// Shared opcode and FSM encodings for the shift execute unit.
package shift_exec_unit_pkg;

  typedef enum logic [1:0] {
    OP_LSL = 2'b00,
    OP_LSR = 2'b01,
    OP_ROL = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PASS1 = 2'b01,
    ST_PASS2 = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // Shifter direction control: 0 shifts toward the MSB, 1 toward the LSB.
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Rotates need a second, opposite-direction pass to bring the wrapped bits back in.
  function automatic logic op_is_rotate(input op_e o);
    return (o == OP_ROL) || (o == OP_ROR);
  endfunction

  // Direction of the first (or only) shifter pass for an opcode.
  function automatic logic op_first_dir(input op_e o);
    return ((o == OP_LSR) || (o == OP_ROR)) ? DIR_RIGHT : DIR_LEFT;
  endfunction

endpackage

// File: rtl/shift_exec_unit_shifter.sv
// Purely combinational logical shifter; amount limited to 0..W-1.
module n_bit_shifter
  import shift_exec_unit_pkg::*;
#(
  parameter int max_s_bits = 3
) (
  input  logic [(2**max_s_bits)-1:0] data_in,
  input  logic [max_s_bits-1:0]      amount,
  input  logic                       dir,
  output logic [(2**max_s_bits)-1:0] data_out
);

  // Zero-filling shift in the requested direction.
  always_comb begin
    if (dir == DIR_LEFT) begin
      data_out = data_in << amount;
    end else begin
      data_out = data_in >> amount;
    end
  end

endmodule

// File: rtl/shift_exec_unit.sv
// Sequential shift/rotate execute stage built around one shared n_bit_shifter.
// LSL/LSR finish in one shifter pass; ROL/ROR combine two opposite passes.
module shift_exec_unit
  import shift_exec_unit_pkg::*;
#(
  parameter int max_s_bits = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 op,
  input  logic [(2**max_s_bits)-1:0] a,
  input  logic [(2**max_s_bits)-1:0] b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [(2**max_s_bits)-1:0] result,
  output logic                       flag_z,
  output logic                       flag_c,
  output logic                       busy
);

  localparam int W = 2**max_s_bits;

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [W-1:0]          a_q, a_d;
  logic [W-1:0]          b_q, b_d;
  logic [W-1:0]          partial_q, partial_d;
  logic [W-1:0]          result_q, result_d;
  logic                  flag_z_q, flag_z_d;
  logic                  flag_c_q, flag_c_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_ready_q, in_ready_d;
  logic                  busy_q, busy_d;

  logic [max_s_bits-1:0] sh_amt_s;
  logic                  sh_dir_s;
  logic [W-1:0]          sh_out_s;
  logic [max_s_bits-1:0] rot_r_s;
  logic                  k_big_s;
  logic [W-1:0]          shift_res_s;
  logic [W-1:0]          rot_res_s;

  // Last bit shifted out of an LSL by k (1..W); zero for k==0 or k>W.
  function automatic logic lsl_carry(input logic [W-1:0] d, input logic [W-1:0] k);
    logic c;
    c = 1'b0;
    for (int i = 1; i <= W; i++) begin
      c = (k == W'(i)) ? d[W-i] : c;
    end
    return c;
  endfunction

  // Last bit shifted out of an LSR by k (1..W); zero for k==0 or k>W.
  function automatic logic lsr_carry(input logic [W-1:0] d, input logic [W-1:0] k);
    logic c;
    c = 1'b0;
    for (int i = 1; i <= W; i++) begin
      c = (k == W'(i)) ? d[i-1] : c;
    end
    return c;
  endfunction

  // Rotate amount is k mod W; any upper amount bit means a plain shift clears everything.
  assign rot_r_s = b_q[max_s_bits-1:0];
  assign k_big_s = |b_q[W-1:max_s_bits];

  n_bit_shifter #(.max_s_bits(max_s_bits)) u_shifter (
    .data_in  (a_q),
    .amount   (sh_amt_s),
    .dir      (sh_dir_s),
    .data_out (sh_out_s)
  );

  // Shifter control: pass 2 shifts by W-r in the opposite direction, otherwise by k.
  always_comb begin
    case (state_q)
      ST_PASS2: begin
        sh_amt_s = {max_s_bits{1'b0}} - rot_r_s;
        sh_dir_s = ~op_first_dir(op_q);
      end
      default: begin
        sh_amt_s = rot_r_s;
        sh_dir_s = op_first_dir(op_q);
      end
    endcase
  end

  // Candidate results: clamped shift for LSL/LSR, merged passes for rotates (r==0 keeps a).
  always_comb begin
    shift_res_s = k_big_s ? {W{1'b0}} : sh_out_s;
    if (rot_r_s == {max_s_bits{1'b0}}) begin
      rot_res_s = partial_q;
    end else begin
      rot_res_s = partial_q | sh_out_s;
    end
  end

  // FSM next state, operand capture, and result/flag computation.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    partial_d = partial_q;
    result_d  = result_q;
    flag_z_d  = flag_z_q;
    flag_c_d  = flag_c_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          op_d    = op_e'(op);
          a_d     = a;
          b_d     = b;
          state_d = ST_PASS1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PASS1: begin
        if (op_is_rotate(op_q)) begin
          partial_d = sh_out_s;
          state_d   = ST_PASS2;
        end else begin
          result_d = shift_res_s;
          flag_z_d = (shift_res_s == {W{1'b0}});
          flag_c_d = (op_q == OP_LSL) ? lsl_carry(a_q, b_q) : lsr_carry(a_q, b_q);
          state_d  = ST_DONE;
        end
      end
      ST_PASS2: begin
        result_d = rot_res_s;
        flag_z_d = (rot_res_s == {W{1'b0}});
        if (rot_r_s == {max_s_bits{1'b0}}) begin
          flag_c_d = 1'b0;
        end else if (op_q == OP_ROL) begin
          flag_c_d = rot_res_s[0];
        end else begin
          flag_c_d = rot_res_s[W-1];
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    out_valid_d = (state_d == ST_DONE);
    in_ready_d  = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_LSL;
      a_q         <= {W{1'b0}};
      b_q         <= {W{1'b0}};
      partial_q   <= {W{1'b0}};
      result_q    <= {W{1'b0}};
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      partial_q   <= partial_d;
      result_q    <= result_d;
      flag_z_q    <= flag_z_d;
      flag_c_q    <= flag_c_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flag_z    = flag_z_q;
  assign flag_c    = flag_c_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_shift_exec_unit.sv
// Scoreboard bench for shift_exec_unit (W=8): directed vectors with hand-computed results.
module tb_shift_exec_unit;

  localparam logic [1:0] T_LSL = 2'b00;
  localparam logic [1:0] T_LSR = 2'b01;
  localparam logic [1:0] T_ROL = 2'b10;
  localparam logic [1:0] T_ROR = 2'b11;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       flag_z;
  logic       flag_c;
  logic       busy;

  typedef struct {
    logic [7:0] res;
    logic       z;
    logic       c;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_ov = 1'b0;

  shift_exec_unit #(.max_s_bits(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one request; push the expectation tagged with the accept cycle.
  task automatic send(input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] er, input logic ec, input int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    op = o;
    a = av;
    b = bv;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: op=%0d a=%h b=%h never accepted", o, av, bv);
      in_valid = 1'b0;
    end else begin
      sb_q.push_back('{er, (er == 8'h00), ec, lat, cyc});
      @(negedge clk);
      in_valid = 1'b0;
      op = ~o;
      a = ~av;
      b = ~bv;
    end
  endtask

  // Monitor: checks latency on first out_valid, contents every valid cycle, pops on handshake.
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: result=%h with empty scoreboard", result);
        end else begin
          mon_e = sb_q[0];
          if (!prev_ov) chk("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
          chk("result", {24'h0, result}, {24'h0, mon_e.res});
          chk("flag_z", {31'h0, flag_z}, {31'h0, mon_e.z});
          chk("flag_c", {31'h0, flag_c}, {31'h0, mon_e.c});
          chk("in_ready_in_done", {31'h0, in_ready}, 32'h0);
          if (out_ready) void'(sb_q.pop_front());
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("drain", 32'(sb_q.size()), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int guard;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    op = 2'b00;
    a = 8'h00;
    b = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_result", {24'h0, result}, 32'h0);
    chk("rst_flag_z", {31'h0, flag_z}, 32'h0);
    chk("rst_flag_c", {31'h0, flag_c}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'h0, in_ready}, 32'h1);

    // Plain shifts, including k==0, k==W, k>W.
    send(T_LSL, 8'hB5, 8'd3,   8'hA8, 1'b1, 2);
    send(T_LSR, 8'h81, 8'd1,   8'h40, 1'b1, 2);
    send(T_LSR, 8'h81, 8'd9,   8'h00, 1'b0, 2);
    send(T_LSL, 8'h01, 8'd8,   8'h00, 1'b1, 2);
    send(T_LSR, 8'h81, 8'd8,   8'h00, 1'b1, 2);
    send(T_LSL, 8'hB5, 8'd0,   8'hB5, 1'b0, 2);
    send(T_LSR, 8'hF0, 8'd7,   8'h01, 1'b1, 2);
    send(T_LSL, 8'h80, 8'd255, 8'h00, 1'b0, 2);
    // Rotates, including r==0, k==W-1, k>W.
    send(T_ROR, 8'h81, 8'd1,   8'hC0, 1'b1, 3);
    send(T_ROL, 8'h96, 8'd8,   8'h96, 1'b0, 3);
    send(T_ROR, 8'h96, 8'd3,   8'hD2, 1'b1, 3);
    send(T_ROL, 8'h01, 8'd7,   8'h80, 1'b0, 3);
    send(T_ROL, 8'h0F, 8'd12,  8'hF0, 1'b0, 3);
    send(T_ROR, 8'h00, 8'd5,   8'h00, 1'b0, 3);
    drain();

    // Backpressure in DONE with a second request held pending.
    out_ready = 1'b0;
    send(T_LSL, 8'hB5, 8'd3, 8'hA8, 1'b1, 2);
    fork
      send(T_LSL, 8'h01, 8'd1, 8'h02, 1'b0, 2);
      begin
        guard = 0;
        while (!out_valid && guard < 20) begin
          @(negedge clk);
          guard++;
        end
        chk("bp_out_valid_seen", {31'h0, out_valid}, 32'h1);
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_after_release", {31'h0, in_ready}, 32'h1);
        chk("bp_valid_dropped", {31'h0, out_valid}, 32'h0);
      end
    join
    drain();

    // Leave nonzero result and flag_c so the reset check below is meaningful.
    send(T_ROL, 8'h96, 8'd4, 8'h69, 1'b1, 3);
    drain();

    // Asynchronous reset during PASS2 of a rotate.
    @(negedge clk);
    chk("ready_before_rst_op", {31'h0, in_ready}, 32'h1);
    in_valid = 1'b1;
    op = T_ROR;
    a = 8'h81;
    b = 8'h01;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("busy_in_pass2", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    chk("async_out_valid", {31'h0, out_valid}, 32'h0);
    chk("async_result", {24'h0, result}, 32'h0);
    chk("async_flag_z", {31'h0, flag_z}, 32'h0);
    chk("async_flag_c", {31'h0, flag_c}, 32'h0);
    chk("async_busy", {31'h0, busy}, 32'h0);
    chk("async_in_ready", {31'h0, in_ready}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", {31'h0, in_ready}, 32'h1);
    chk("not_busy_after_rst", {31'h0, busy}, 32'h0);
    send(T_LSL, 8'hFF, 8'd4, 8'hF0, 1'b1, 2);
    drain();

    repeat (3) @(negedge clk);
    chk("no_stray_output", {31'h0, out_valid}, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
